if_fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS core. Owns the fetch address and drives it into the PC register, requests instruction words from instruction memory over a req/ack handshake, and presents fetched instructions to the decode stage through a two-entry buffer (output register plus skid). Handles decode back-pressure (`stall`) and branch/jump redirects from execute, including redirects that arrive while a memory request is outstanding.

---
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 tb/tb_if_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage.
// Owns the fetch address (pc_next), requests instruction words from instruction
// memory over a req/ack handshake, and hands them to decode through a
// two-entry buffer: an output register plus one skid entry.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   redirect            branch/jump taken in execute (one-cycle pulse)
//   redirect_pc         redirect target, low two bits forced to zero
//   stall               decode back-pressure; consume = instr_valid && !stall
//   imem_req            memory request, high only while waiting on memory
//   imem_addr           request address (equals pc_next)
//   imem_ack            memory response valid, ignored while imem_req is low
//   imem_rdata          instruction word returned with imem_ack
//   pc_next             registered fetch address for the PC register
//   instr_valid         instr_out / instr_pc hold a valid instruction
//   instr_out           fetched instruction word
//   instr_pc            address of instr_out
module if_fetch_unit #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect,
  input  logic [BUS_WIDTH-1:0] redirect_pc,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [BUS_WIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  output logic [BUS_WIDTH-1:0] pc_next,
  output logic                 instr_valid,
  output logic [BUS_WIDTH-1:0] instr_out,
  output logic [BUS_WIDTH-1:0] instr_pc
);

  typedef enum logic [1:0] {StIdle, StWait, StFull} state_e;

  state_e               state_q;
  logic                 skid_valid_q;
  logic [BUS_WIDTH-1:0] skid_data_q;
  logic [BUS_WIDTH-1:0] skid_pc_q;
  // Kill marks the in-flight request as stale after a redirect; its ack is dropped.
  logic                 kill_q;
  logic [BUS_WIDTH-1:0] kill_pc_q;

  logic                 consume;
  logic                 ack;
  logic [BUS_WIDTH-1:0] target_pc;

  assign imem_req  = (state_q == StWait);
  assign imem_addr = pc_next;
  assign consume   = instr_valid && !stall;
  assign ack       = imem_req && imem_ack;
  assign target_pc = {redirect_pc[BUS_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_next      <= RESET_PC;
      instr_valid  <= 1'b0;
      instr_out    <= '0;
      instr_pc     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
      kill_q       <= 1'b0;
      kill_pc_q    <= '0;
    end else if (redirect) begin
      instr_valid  <= 1'b0;
      skid_valid_q <= 1'b0;
      state_q      <= StWait;
      if (state_q == StWait && !ack) begin
        // Request still outstanding: keep the address stable and drop its ack later.
        kill_q    <= 1'b1;
        kill_pc_q <= target_pc;
      end else begin
        kill_q  <= 1'b0;
        pc_next <= target_pc;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StWait;
        end
        StWait: begin
          if (ack && kill_q) begin
            kill_q  <= 1'b0;
            pc_next <= kill_pc_q;
          end else if (ack) begin
            pc_next <= pc_next + BUS_WIDTH'(4);
            if (consume && skid_valid_q) begin
              // Older skid entry goes out first; the new word takes its place.
              instr_out   <= skid_data_q;
              instr_pc    <= skid_pc_q;
              skid_data_q <= imem_rdata;
              skid_pc_q   <= pc_next;
              state_q     <= StFull;
            end else if (consume || !instr_valid) begin
              instr_valid <= 1'b1;
              instr_out   <= imem_rdata;
              instr_pc    <= pc_next;
            end else begin
              skid_valid_q <= 1'b1;
              skid_data_q  <= imem_rdata;
              skid_pc_q    <= pc_next;
              state_q      <= StFull;
            end
          end else if (consume) begin
            instr_valid  <= skid_valid_q;
            instr_out    <= skid_valid_q ? skid_data_q : instr_out;
            instr_pc     <= skid_valid_q ? skid_pc_q : instr_pc;
            skid_valid_q <= 1'b0;
          end
        end
        StFull: begin
          if (consume) begin
            instr_valid  <= skid_valid_q;
            instr_out    <= skid_data_q;
            instr_pc     <= skid_pc_q;
            skid_valid_q <= 1'b0;
            state_q      <= StWait;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Inputs change #1 after each rising edge;
// outputs are compared at that same point, after the edge has settled.
module tb_if_fetch_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         stall;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic [W-1:0] pc_next;
  logic         instr_valid;
  logic [W-1:0] instr_out;
  logic [W-1:0] instr_pc;

  int unsigned n_cmp;
  int unsigned n_err;

  if_fetch_unit #(
    .BUS_WIDTH(W),
    .RESET_PC ('0)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_next    (pc_next),
    .instr_valid(instr_valid),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each word is a fixed scramble of its address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with an ack carrying the word at the given address.
  task automatic ack_cycle(input logic [W-1:0] a);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(a);
    step();
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    #1;

    // Reset state
    step();
    check_eq("rst_req", W'(imem_req), 0);
    check_eq("rst_valid", W'(instr_valid), 0);
    check_eq("rst_pc_next", pc_next, 0);
    check_eq("rst_instr_out", instr_out, 0);
    check_eq("rst_instr_pc", instr_pc, 0);
    rst = 1'b0;
    step();
    check_eq("wait_req", W'(imem_req), 1);
    check_eq("wait_addr", imem_addr, 0);

    // Zero-wait streaming
    for (int k = 0; k < 4; k++) begin
      ack_cycle(W'(4 * k));
      check_eq("stream_valid", W'(instr_valid), 1);
      check_eq("stream_pc", instr_pc, W'(4 * k));
      check_eq("stream_data", instr_out, mem_word(W'(4 * k)));
    end
    check_eq("stream_pc_next", pc_next, 32'h10);

    // Stall for 3 cycles: word 0x10 goes to skid, then FULL with req low
    stall = 1'b1;
    ack_cycle(32'h10);
    check_eq("stall_req", W'(imem_req), 0);
    check_eq("stall_hold_pc", instr_pc, 32'hC);
    check_eq("stall_pc_next", pc_next, 32'h14);
    for (int k = 0; k < 2; k++) begin
      ack_cycle(32'h14);  // ack ignored while req is low
      check_eq("full_req", W'(imem_req), 0);
      check_eq("full_hold_pc", instr_pc, 32'hC);
      check_eq("full_pc_next", pc_next, 32'h14);
    end
    stall = 1'b0;
    ack_cycle(32'h14);
    check_eq("release_skid_pc", instr_pc, 32'h10);
    check_eq("release_skid_data", instr_out, mem_word(32'h10));
    check_eq("release_valid", W'(instr_valid), 1);
    check_eq("release_req", W'(imem_req), 1);
    ack_cycle(32'h14);
    check_eq("resume_pc", instr_pc, 32'h14);
    check_eq("resume_data", instr_out, mem_word(32'h14));

    // Redirect to 0x100 while a request to 0x18 is pending
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check_eq("kill_flush", W'(instr_valid), 0);
    check_eq("kill_addr_hold", imem_addr, 32'h18);
    step();
    check_eq("kill_addr_hold2", imem_addr, 32'h18);
    ack_cycle(32'h18);
    check_eq("kill_drop", W'(instr_valid), 0);
    check_eq("kill_new_addr", imem_addr, 32'h100);
    ack_cycle(32'h100);
    check_eq("redir_valid", W'(instr_valid), 1);
    check_eq("redir_pc", instr_pc, 32'h100);
    check_eq("redir_data", instr_out, mem_word(32'h100));

    // Redirect to 0x40 together with an ack
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    ack_cycle(32'h104);
    redirect = 1'b0;
    check_eq("redack_valid", W'(instr_valid), 0);
    check_eq("redack_pc_next", pc_next, 32'h40);
    ack_cycle(32'h40);
    check_eq("redack_first_pc", instr_pc, 32'h40);

    // Unaligned target and address wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    ack_cycle(32'h44);
    redirect = 1'b0;
    check_eq("wrap_align", pc_next, 32'hFFFF_FFFC);
    ack_cycle(32'hFFFF_FFFC);
    check_eq("wrap_top_pc", instr_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc_next", pc_next, 32'h0);
    ack_cycle(32'h0);
    check_eq("wrap_next_pc", instr_pc, 32'h0);

    // Redirect while FULL
    stall = 1'b1;
    ack_cycle(32'h4);
    check_eq("full2_req", W'(imem_req), 0);
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check_eq("fullred_valid", W'(instr_valid), 0);
    check_eq("fullred_addr", imem_addr, 32'h200);
    check_eq("fullred_req", W'(imem_req), 1);
    ack_cycle(32'h200);
    check_eq("fullred_first_pc", instr_pc, 32'h200);

    // Reset with a request pending, then a late ack
    imem_ack = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_req", W'(imem_req), 0);
    check_eq("midrst_valid", W'(instr_valid), 0);
    check_eq("midrst_pc_next", pc_next, 32'h0);
    ack_cycle(32'h204);
    check_eq("late_ack_valid", W'(instr_valid), 0);
    check_eq("late_ack_pc_next", pc_next, 32'h0);
    check_eq("late_ack_req", W'(imem_req), 1);
    ack_cycle(32'h0);
    check_eq("post_rst_pc", instr_pc, 32'h0);
    check_eq("post_rst_data", instr_out, mem_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
